// File: rtl/isqrt_sum_n_fsm.sv
// Sums the integer square roots of N_ARGS operands by time-sharing N_ISQRT external isqrt units.
// Optional ISQRT_SUM_CYCLES_EN adds a res_cycles output (acceptance-to-result cycle count).

// state | meaning
// IDLE  | arg_rdy high, waiting for an operand set
// ISSUE | one-cycle request strobe to the units used by the current round
// WAIT  | collecting roots until every pending unit has answered
// DONE  | one-cycle result strobe
module isqrt_sum_n_fsm #(
  parameter int W       = 32,
  parameter int N_ARGS  = 3,
  parameter int N_ISQRT = 2,
  parameter int RES_W   = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      arg_vld,
  output logic                      arg_rdy,
  input  logic [N_ARGS*W-1:0]       args,
  output logic                      res_vld,
  output logic [RES_W-1:0]          res,
  output logic [N_ISQRT-1:0]        isqrt_x_vld,
  output logic [N_ISQRT*W-1:0]      isqrt_x,
  input  logic [N_ISQRT-1:0]        isqrt_y_vld,
  input  logic [N_ISQRT*(W/2)-1:0]  isqrt_y
`ifdef ISQRT_SUM_CYCLES_EN
  ,
  output logic [15:0]               res_cycles
`endif
);

  localparam int HW       = W / 2;
  localparam int N_ROUNDS = (N_ARGS + N_ISQRT - 1) / N_ISQRT;
  localparam int RW       = (N_ROUNDS > 1) ? $clog2(N_ROUNDS) : 1;
  localparam logic [RW-1:0] LAST_ROUND = RW'(N_ROUNDS - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t                 state, state_nxt;
  logic [N_ARGS*W-1:0]    args_q;
  logic [RES_W-1:0]       acc, acc_nxt;
  logic [N_ISQRT-1:0]     pending, pending_nxt, taken, hit;
  logic [RW-1:0]          round;
  logic                   finish;

  // Per-unit operand mux: unit j in round r serves operand r*N_ISQRT+j, if it exists.
  for (genvar j = 0; j < N_ISQRT; j++) begin : g_unit
    logic [N_ROUNDS-1:0]        sel;
    logic [N_ROUNDS-1:0][W-1:0] opr;
    logic [W-1:0]               op;

    for (genvar r = 0; r < N_ROUNDS; r++) begin : g_round
      if (r * N_ISQRT + j < N_ARGS) begin : g_on
        assign sel[r] = (round == RW'(r));
        assign opr[r] = args_q[(r*N_ISQRT+j)*W +: W];
      end else begin : g_off
        assign sel[r] = 1'b0;
        assign opr[r] = '0;
      end
    end

    always_comb begin
      op = '0;
      for (int r = 0; r < N_ROUNDS; r++) op = op | (opr[r] & {W{sel[r]}});
    end

    assign hit[j]              = |sel;
    assign isqrt_x_vld[j]      = (state == ISSUE) && hit[j];
    assign isqrt_x[j*W +: W]   = isqrt_x_vld[j] ? op : '0;
  end

  // Only units with an outstanding request may contribute; stray strobes fall out here.
  always_comb begin
    taken       = isqrt_y_vld & pending;
    acc_nxt     = acc;
    for (int j = 0; j < N_ISQRT; j++) begin
      if (taken[j]) acc_nxt = acc_nxt + RES_W'(isqrt_y[j*HW +: HW]);
    end
    pending_nxt = pending & ~taken;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (arg_vld) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (pending_nxt == '0) state_nxt = (round == LAST_ROUND) ? DONE : ISSUE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign arg_rdy = (state == IDLE);
  assign res_vld = (state == DONE);
  assign finish  = (state == WAIT) && (state_nxt == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      args_q  <= '0;
      acc     <= '0;
      pending <= '0;
      round   <= '0;
      res     <= '0;
    end else begin
      state   <= state_nxt;
      acc     <= acc_nxt;
      pending <= pending_nxt;
      case (state)
        IDLE: begin
          if (arg_vld) begin
            args_q <= args;
            acc    <= '0;
            round  <= '0;
            res    <= '0;
          end
        end
        ISSUE: pending <= pending_nxt | hit;
        WAIT: begin
          if (pending_nxt == '0 && round != LAST_ROUND) round <= round + 1'b1;
          if (finish) res <= acc_nxt;
        end
        default: ;
      endcase
    end
  end

`ifdef ISQRT_SUM_CYCLES_EN
  logic [15:0] cyc;

  // cyc equals the number of edges since acceptance, so the DONE cycle sees cyc+1 loaded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc        <= '0;
      res_cycles <= '0;
    end else begin
      if (state == IDLE && arg_vld) begin
        cyc        <= 16'd1;
        res_cycles <= '0;
      end else if (cyc != 16'hFFFF) begin
        cyc <= cyc + 16'd1;
      end
      if (finish) res_cycles <= (cyc == 16'hFFFF) ? 16'hFFFF : cyc + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_isqrt_sum_n_fsm.sv
// Directed bench for isqrt_sum_n_fsm: three configurations, each with a simple
// fixed-latency isqrt unit model per instance.
module tb_isqrt_sum_n_fsm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  function automatic logic [15:0] isqrt32(input logic [31:0] v);
    logic [31:0] r;
    logic [63:0] t;
    r = '0;
    for (int b = 15; b >= 0; b--) begin
      t = {32'd0, r | (32'd1 << b)};
      if (t * t <= {32'd0, v}) r = r | (32'd1 << b);
    end
    return r[15:0];
  endfunction

  // ---------------- DUT a: defaults, both units latency 4
  logic        a_rst, a_avld, a_ardy, a_rvld;
  logic [95:0] a_args;
  logic [31:0] a_res;
  logic [1:0]  a_xv, a_yv;
  logic [63:0] a_x;
  logic [31:0] a_y;
  int          a_cnt [2];
  logic [31:0] a_op  [2];
`ifdef ISQRT_SUM_CYCLES_EN
  logic [15:0] a_rc;
`endif

  isqrt_sum_n_fsm u_a (
    .clk(clk), .rst(a_rst), .arg_vld(a_avld), .arg_rdy(a_ardy), .args(a_args),
    .res_vld(a_rvld), .res(a_res), .isqrt_x_vld(a_xv), .isqrt_x(a_x),
    .isqrt_y_vld(a_yv), .isqrt_y(a_y)
`ifdef ISQRT_SUM_CYCLES_EN
    , .res_cycles(a_rc)
`endif
  );

  always @(posedge clk)
    for (int j = 0; j < 2; j++) begin
      if (a_xv[j]) begin
        a_cnt[j] <= 4;
        a_op[j]  <= a_x[j*32 +: 32];
      end else if (a_cnt[j] > 0) a_cnt[j] <= a_cnt[j] - 1;
    end

  always_comb begin
    a_yv = '0;
    a_y  = '0;
    for (int j = 0; j < 2; j++)
      if (a_cnt[j] == 1) begin
        a_yv[j]         = 1'b1;
        a_y[j*16 +: 16] = isqrt32(a_op[j]);
      end
  end

  // ---------------- DUT b: N_ARGS=5, both units latency 4
  logic         b_rst, b_avld, b_ardy, b_rvld;
  logic [159:0] b_args;
  logic [31:0]  b_res;
  logic [1:0]   b_xv, b_yv;
  logic [63:0]  b_x;
  logic [31:0]  b_y;
  int           b_cnt [2];
  logic [31:0]  b_op  [2];
`ifdef ISQRT_SUM_CYCLES_EN
  logic [15:0]  b_rc;
`endif

  isqrt_sum_n_fsm #(.N_ARGS(5)) u_b (
    .clk(clk), .rst(b_rst), .arg_vld(b_avld), .arg_rdy(b_ardy), .args(b_args),
    .res_vld(b_rvld), .res(b_res), .isqrt_x_vld(b_xv), .isqrt_x(b_x),
    .isqrt_y_vld(b_yv), .isqrt_y(b_y)
`ifdef ISQRT_SUM_CYCLES_EN
    , .res_cycles(b_rc)
`endif
  );

  always @(posedge clk)
    for (int j = 0; j < 2; j++) begin
      if (b_xv[j]) begin
        b_cnt[j] <= 4;
        b_op[j]  <= b_x[j*32 +: 32];
      end else if (b_cnt[j] > 0) b_cnt[j] <= b_cnt[j] - 1;
    end

  always_comb begin
    b_yv = '0;
    b_y  = '0;
    for (int j = 0; j < 2; j++)
      if (b_cnt[j] == 1) begin
        b_yv[j]         = 1'b1;
        b_y[j*16 +: 16] = isqrt32(b_op[j]);
      end
  end

  // ---------------- DUT c: N_ARGS=4, unit 0 latency 2, unit 1 latency 7
  logic         c_rst, c_avld, c_ardy, c_rvld;
  logic [127:0] c_args;
  logic [31:0]  c_res;
  logic [1:0]   c_xv, c_yv;
  logic [63:0]  c_x;
  logic [31:0]  c_y;
  int           c_cnt [2];
  logic [31:0]  c_op  [2];
`ifdef ISQRT_SUM_CYCLES_EN
  logic [15:0]  c_rc;
`endif

  isqrt_sum_n_fsm #(.N_ARGS(4)) u_c (
    .clk(clk), .rst(c_rst), .arg_vld(c_avld), .arg_rdy(c_ardy), .args(c_args),
    .res_vld(c_rvld), .res(c_res), .isqrt_x_vld(c_xv), .isqrt_x(c_x),
    .isqrt_y_vld(c_yv), .isqrt_y(c_y)
`ifdef ISQRT_SUM_CYCLES_EN
    , .res_cycles(c_rc)
`endif
  );

  always @(posedge clk)
    for (int j = 0; j < 2; j++) begin
      if (c_xv[j]) begin
        c_cnt[j] <= (j == 0) ? 2 : 7;
        c_op[j]  <= c_x[j*32 +: 32];
      end else if (c_cnt[j] > 0) c_cnt[j] <= c_cnt[j] - 1;
    end

  always_comb begin
    c_yv = '0;
    c_y  = '0;
    for (int j = 0; j < 2; j++)
      if (c_cnt[j] == 1) begin
        c_yv[j]         = 1'b1;
        c_y[j*16 +: 16] = isqrt32(c_op[j]);
      end
  end

  // ---------------- stimulus
  typedef struct packed {
    logic [31:0] a0;
    logic [31:0] a1;
    logic [31:0] a2;
    logic [31:0] exp_res;
  } vec_t;

  vec_t        vt [6];
  logic [31:0] rres, rres2;
  int          lat, got, at, at2;

  // Accepts one operand set on DUT a and returns the first result and its latency (0 on timeout).
  task automatic run_a(input logic [31:0] x0, x1, x2, output logic [31:0] r, output int l);
    int g;
    g = 0;
    @(negedge clk);
    a_args = {x2, x1, x0};
    a_avld = 1'b1;
    while (!a_ardy && g < 50) begin
      @(negedge clk);
      g++;
    end
    @(posedge clk);
    l = 0;
    r = '0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) a_avld = 1'b0;
      if (a_rvld && l == 0) begin
        l = k;
        r = a_res;
      end
    end
  endtask

  initial begin
    vt[0] = '{a0: 32'd1,          a1: 32'd4,          a2: 32'd9,          exp_res: 32'd6};
    vt[1] = '{a0: 32'hFFFF_FFFF,  a1: 32'hFFFF_FFFF,  a2: 32'hFFFF_FFFF,  exp_res: 32'd196605};
    vt[2] = '{a0: 32'd0,          a1: 32'd0,          a2: 32'd0,          exp_res: 32'd0};
    vt[3] = '{a0: 32'd2,          a1: 32'd3,          a2: 32'd15,         exp_res: 32'd5};
    vt[4] = '{a0: 32'd16,         a1: 32'd25,         a2: 32'd100,        exp_res: 32'd19};
    vt[5] = '{a0: 32'd1000000,    a1: 32'd999999,     a2: 32'd3,          exp_res: 32'd2000};

    a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;
    a_avld = 1'b0; b_avld = 1'b0; c_avld = 1'b0;
    a_args = '0; b_args = '0; c_args = '0;
    repeat (3) @(negedge clk);
    check("rst_arg_rdy", a_ardy, 1);
    check("rst_res_vld", a_rvld, 0);
    check("rst_res", a_res, 0);
    check("rst_x_vld", a_xv, 0);
    check("rst_x", a_x, 0);
    a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;
    @(negedge clk);

    // Round structure for {1,4,9}
    a_args = {32'd9, 32'd4, 32'd1};
    a_avld = 1'b1;
    @(posedge clk);
    got = 0; at = 0; rres = '0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) begin
        a_avld = 1'b0;
        check("a_round1_x_vld", a_xv, 2'b11);
        check("a_round1_x", a_x, {32'd4, 32'd1});
      end
      if (k == 3) begin
        check("a_busy_arg_rdy", a_ardy, 0);
        check("a_wait_x_vld", a_xv, 0);
      end
      if (k == 6) begin
        check("a_round2_x_vld", a_xv, 2'b01);
        check("a_round2_x", a_x, {32'd0, 32'd9});
      end
      if (a_rvld) begin
        got++;
        at = k;
        rres = a_res;
      end
    end
    check("a_res", rres, 6);
    check("a_latency", at, 11);
    check("a_strobes", got, 1);
    check("a_res_held", a_res, 6);
`ifdef ISQRT_SUM_CYCLES_EN
    check("a_res_cycles", a_rc, 11);
`endif

    for (int i = 0; i < 6; i++) begin
      run_a(vt[i].a0, vt[i].a1, vt[i].a2, rres, lat);
      check($sformatf("vec%0d_res", i), rres, vt[i].exp_res);
      check($sformatf("vec%0d_latency", i), lat, 11);
`ifdef ISQRT_SUM_CYCLES_EN
      check($sformatf("vec%0d_res_cycles", i), a_rc, 11);
`endif
    end

    // arg_vld held high with changing args: only the latched set counts
    @(negedge clk);
    a_args = {32'd9, 32'd4, 32'd1};
    a_avld = 1'b1;
    @(posedge clk);
    got = 0; at = 0; at2 = 0; rres = '0; rres2 = '0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k <= 10) a_args = {$urandom, $urandom, $urandom};
      if (k == 11) a_args = {32'd100, 32'd100, 32'd100};
      if (k == 13) a_avld = 1'b0;
      if (k == 5) check("hold_arg_rdy", a_ardy, 0);
      if (k == 12) check("hold_idle_arg_rdy", a_ardy, 1);
      if (a_rvld) begin
        got++;
        if (got == 1) begin at = k; rres = a_res; end
        else begin at2 = k; rres2 = a_res; end
      end
    end
    check("hold_strobes", got, 2);
    check("hold_first_res", rres, 6);
    check("hold_first_latency", at, 11);
    check("hold_second_res", rres2, 30);
    check("hold_second_at", at2, 23);

    // Reset during WAIT
    @(negedge clk);
    a_args = {32'd4, 32'd4, 32'd4};
    a_avld = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (k == 1) a_avld = 1'b0;
    end
    a_rst = 1'b1;
    #1;
    check("midrst_arg_rdy", a_ardy, 1);
    check("midrst_res_vld", a_rvld, 0);
    check("midrst_res", a_res, 0);
    check("midrst_x_vld", a_xv, 0);
    check("midrst_x", a_x, 0);
    @(negedge clk);
    a_rst = 1'b0;
    got = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (a_rvld) got++;
    end
    check("midrst_no_strobe", got, 0);
    run_a(32'd16, 32'd16, 32'd16, rres, lat);
    check("after_rst_res", rres, 12);
    check("after_rst_latency", lat, 11);

    // N_ARGS=5: three rounds, last one drives only unit 0
    @(negedge clk);
    b_args = {32'd65536, 32'd256, 32'd16, 32'd1, 32'd0};
    b_avld = 1'b1;
    @(posedge clk);
    got = 0; at = 0; rres = '0;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      if (k == 1) begin
        b_avld = 1'b0;
        check("b_round1_x_vld", b_xv, 2'b11);
        check("b_round1_x", b_x, {32'd1, 32'd0});
      end
      if (k == 6) begin
        check("b_round2_x_vld", b_xv, 2'b11);
        check("b_round2_x", b_x, {32'd256, 32'd16});
      end
      if (k == 11) begin
        check("b_round3_x_vld", b_xv, 2'b01);
        check("b_round3_x", b_x, {32'd0, 32'd65536});
      end
      if (b_rvld) begin
        got++;
        at = k;
        rres = b_res;
      end
    end
    check("b_res", rres, 277);
    check("b_latency", at, 16);
    check("b_strobes", got, 1);

    // Unequal unit latencies, results out of order
    @(negedge clk);
    c_args = {32'd9, 32'd9, 32'd9, 32'd9};
    c_avld = 1'b1;
    @(posedge clk);
    got = 0; at = 0; rres = '0;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      if (k == 1) c_avld = 1'b0;
      if (c_rvld) begin
        got++;
        at = k;
        rres = c_res;
      end
    end
    check("c_res", rres, 12);
    check("c_latency", at, 17);
    check("c_strobes", got, 1);
`ifdef ISQRT_SUM_CYCLES_EN
    check("c_res_cycles", c_rc, 17);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
